mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative HI/LO multiply/divide unit for MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO.
//  Sits directly downstream of the register file and consumes its two read ports
//  (rs -> a, rt -> b) in the EX stage.
//  Owns the architectural HI/LO registers. Reports busy so the hazard logic can stall
//  MFHI/MFLO and new mul/div ops.
// PARAMETERS
//  WIDTH   32   operand / HI / LO width; ITER = WIDTH iterations per operation
// PORTS
//  clk    in   1      rising-edge clock
//  rst    in   1      reset, asynchronous, active-high
//  start  in   1      launch op; sampled only in IDLE
//  op     in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a      in   WIDTH  operand rs (dividend / multiplicand)
//  b      in   WIDTH  operand rt (divisor / multiplier)
//  cancel in   1      abort in-flight op (branch flush / exception)
//  whi    in   1      MTHI: write wd into HI
//  wlo    in   1      MTLO: write wd into LO
//  wd     in   WIDTH  MTHI/MTLO data
//  busy   out  1      op in flight (CALC or FINISH)
//  done   out  1      1-cycle pulse: HI/LO updated on the preceding edge
//  hi     out  WIDTH  HI register (MFHI source)
//  lo     out  WIDTH  LO register (MFLO source)
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, hi=lo=0, busy=0, done=0, counter=0. This also
//    applies mid-operation.
//  - States
//    IDLE -start-> CALC
//    CALC -32nd iteration-> FINISH
//    FINISH -> IDLE
//    any state -cancel-> IDLE
//  - Start edge E (IDLE & start & !cancel): latch op and |a|, |b|.
//    Signed ops take two's-complement magnitudes; unsigned ops use raw values.
//    Record sign bits: product/quotient sign = a[31]^b[31]; remainder sign = a[31].
//    counter=0.
//  - CALC: one step per cycle on edges E+1..E+32.
//    Multiply: 64-bit shift-add.
//    Divide: restoring, one quotient bit per edge.
//  - FINISH, edge E+33: apply sign correction and commit.
//    Multiply: {hi,lo} = product. Divide: lo = quotient, hi = remainder.
//    done=1 during the cycle after E+33.
//  - busy=1 from E+1 through E+33 inclusive; busy=0 in the cycle done is high.
//    done is never high together with busy.
//  - start while busy: ignored.
//    cancel has priority over start in the same cycle.
//    cancel in IDLE: no effect.
//  - cancel in CALC/FINISH: IDLE on the next edge; hi/lo unchanged; no done pulse.
//  - whi/wlo: take effect only when busy=0; ignored while busy.
//    In IDLE, whi|wlo together with start: the write lands at E and is later overwritten
//    by the commit.
//  - Divide by zero (b==0): normal latency, no sign correction. lo=32'hFFFF_FFFF, hi=a
//    (raw).
//  - DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0 (wraps, no trap).
//  - hi/lo are plain registers with no combinational bypass; MFHI/MFLO read them directly.
// STRUCTURE
//  - Shared package/header: op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU, state encodings
//    MD_IDLE/MD_CALC/MD_FINISH.
//  - One sub-module, md_iter_core: 64-bit accumulator, operand register and step counter.
//    Performs one shift-add or restore step per enable.
//  - The top level holds the FSM, sign logic, HI/LO registers and MTHI/MTLO writes.
// TESTING
//  1. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//     busy for 33 cycles; done in cycle 34 after start.
//  2. MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
//  3. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIVU a=7, b=2 -> lo=3, hi=1.
//  4. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
//     DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
//  5. Preload hi=0x11, lo=0x22 via whi/wlo; start MULTU 3*4; cancel at cycle 10.
//     Expect no done, hi=0x11, lo=0x22, busy=0 next cycle.
//     A second start at cycle 5 is ignored; whi during busy is ignored.
//  6. Assert rst mid-CALC (cycle 20) -> busy=0, hi=lo=0 immediately.
//     After release, MTLO wd=0xABCD in IDLE -> lo=0xABCD on the next edge.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - shared op and state encodings for the HI/LO multiply/divide unit
package mul_div_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE   = 2'b00,
        MD_CALC   = 2'b01,
        MD_FINISH = 2'b10
    } md_state_e;

endpackage

// File: rtl/mul_div_unit_iter_core.sv
// rtl/mul_div_unit_iter_core.sv - unsigned shift-add multiply / restoring divide datapath, one step per enable
module md_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   acc_lo_in,
    input  logic [WIDTH-1:0]   opnd_in,
    output logic [2*WIDTH-1:0] acc,
    output logic               last
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     sum;

    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        cnt_d  = cnt_q;
        // Divide: acc = {remainder, dividend/quotient}; multiply: acc = {partial product, multiplier}.
        trial  = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
        sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        if (load) begin
            acc_d  = {{WIDTH{1'b0}}, acc_lo_in};
            opnd_d = opnd_in;
            cnt_d  = '0;
        end else if (step) begin
            cnt_d = cnt_q + 1'b1;
            if (is_div) begin
                if (!trial[WIDTH]) acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else               acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
            end else begin
                acc_d = {sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
        end
    end

    assign acc  = acc_q;
    assign last = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative HI/LO multiply/divide unit with MTHI/MTLO and cancel
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             whi,
    input  logic             wlo,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    md_state_e          state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               neg_q, neg_d, rneg_q, rneg_d, divz_q, divz_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic               start_ok, in_signed, in_div, in_divz;
    logic [WIDTH-1:0]   mag_a, mag_b, core_lo_in, core_opnd_in;
    logic               core_step, core_last;
    logic [2*WIDTH-1:0] acc, prod;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        start_ok     = (state_q == MD_IDLE) && start && !cancel;
        in_signed    = (op == MD_MULT) || (op == MD_DIV);
        in_div       = (op == MD_DIV) || (op == MD_DIVU);
        in_divz      = in_div && (b == '0);
        // Divide-by-zero keeps the raw dividend so the remainder comes out as a unchanged.
        mag_a        = (in_signed && a[WIDTH-1] && !in_divz) ? -a : a;
        mag_b        = (in_signed && b[WIDTH-1]) ? -b : b;
        core_lo_in   = in_div ? mag_a : mag_b;
        core_opnd_in = in_div ? mag_b : mag_a;
        core_step    = (state_q == MD_CALC) && !cancel;
    end

    md_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (start_ok),
        .step      (core_step),
        .is_div    (op_q[1]),
        .acc_lo_in (core_lo_in),
        .opnd_in   (core_opnd_in),
        .acc       (acc),
        .last      (core_last)
    );

    always_comb begin
        prod    = neg_q ? -acc : acc;
        quo     = (neg_q && !divz_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem     = (rneg_q && !divz_q) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        divz_d  = divz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (whi) hi_d = wd;
                if (wlo) lo_d = wd;
                if (start_ok) begin
                    state_d = MD_CALC;
                    op_d    = op;
                    neg_d   = in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    rneg_d  = in_signed && a[WIDTH-1];
                    divz_d  = in_divz;
                end
            end
            MD_CALC: begin
                if (cancel)         state_d = MD_IDLE;
                else if (core_last) state_d = MD_FINISH;
            end
            MD_FINISH: begin
                state_d = MD_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (op_q[1]) begin
                        lo_d = quo;
                        hi_d = rem;
                    end else begin
                        {hi_d, lo_d} = prod;
                    end
                end
            end
            default: state_d = MD_IDLE;
        endcase
        busy_d = (state_d != MD_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_IDLE;
            op_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            divz_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            divz_q  <= divz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit against an arithmetic reference model
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, cancel, whi, wlo;
    logic [1:0]  op;
    logic [31:0] a, b, wd;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .whi(whi), .wlo(wlo), .wd(wd),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sp;
        int     sx, sy;
        logic [63:0] up;
        sx = x;
        sy = y;
        case (o)
            2'b00: begin sp = longint'(sx) * longint'(sy); return sp; end
            2'b01: begin up = {32'h0, x} * {32'h0, y}; return up; end
            2'b10: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(sx % sy), 32'(sx / sy)};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (done && busy) chk("done_with_busy", 1, 0);
        if (!rst && done) begin
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else chk("result_hilo", {hi, lo}, exp_q.pop_front());
        end
    end

    task automatic idle_inputs();
        start = 0; cancel = 0; whi = 0; wlo = 0;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic wr);
        int n, bc;
        @(negedge clk);
        op = o; a = x; b = y; start = 1;
        whi = wr; wlo = wr; wd = $urandom;
        exp_q.push_back(model(o, x, y));
        @(posedge clk);
        n = 0; bc = 0;
        do begin
            @(negedge clk);
            idle_inputs();
            n++;
            if (busy) bc++;
        end while (!done && n < 60);
        chk("done_latency", n, 34);
        chk("busy_cycles", bc, 33);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1; idle_inputs(); op = 0; a = 0; b = 0; wd = 0;
        #1;
        chk("reset_state", {30'h0, busy, done, hi, lo}, 0);
        repeat (2) @(negedge clk);
        rst = 0;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(2'b11, 32'd7, 32'd2, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'b11, 32'd5, 32'd0, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 1);

        // Preload, then an op that is cancelled mid-flight.
        @(negedge clk); whi = 1; wd = 32'h11;
        @(negedge clk); whi = 0; wlo = 1; wd = 32'h22;
        @(negedge clk); wlo = 0;
        chk("mthi_mtlo", {hi, lo}, {32'h11, 32'h22});
        op = 2'b01; a = 3; b = 4; start = 1;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            idle_inputs();
            if (c == 5) begin start = 1; op = 2'b00; a = 9; b = 9; whi = 1; wd = 32'hDEAD; end
            if (c == 10) cancel = 1;
        end
        @(negedge clk);
        idle_inputs();
        chk("cancel_busy", busy, 0);
        chk("cancel_hilo", {hi, lo}, {32'h11, 32'h22});
        repeat (40) @(negedge clk);
        chk("cancel_no_done_hilo", {hi, lo}, {32'h11, 32'h22});

        for (int i = 0; i < 30; i++)
            run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)));

        run_op(2'b11, 32'd5, 32'd0, 0);
        // Asynchronous reset in the middle of CALC.
        @(negedge clk); op = 2'b01; a = 32'h1234; b = 32'h5678; start = 1;
        @(posedge clk);
        for (int c = 1; c < 20; c++) begin @(negedge clk); idle_inputs(); end
        @(negedge clk);
        rst = 1;
        #1;
        chk("async_reset", {31'h0, busy, hi, lo}, 0);
        @(negedge clk); rst = 0; wlo = 1; wd = 32'hABCD;
        @(negedge clk); wlo = 0;
        chk("mtlo_after_reset", {hi, lo}, {32'h0, 32'hABCD});

        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0);
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
